// File: rtl/mips_pkg.sv
// Constants shared by the MIPS datapath: register-file geometry, special
// register numbers and the destination-select encoding used by mux41.
package mips_pkg;

    localparam int AW    = 5;
    localparam int WIDTH = 32;

    localparam logic [AW-1:0] REG_ZERO = 5'd0;
    localparam logic [AW-1:0] REG_RA   = 5'd31;

    // Select encoding of the destination-register mux feeding the write address.
    typedef enum logic [1:0] {
        DST_RT    = 2'd0,
        DST_RD    = 2'd1,
        DST_RA    = 2'd2,
        DST_SPARE = 2'd3
    } dst_sel_e;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: forces zero during reset and for $zero,
// otherwise forwards same-cycle write data ahead of the stored word.
module regfile_rdport #(
    parameter int WIDTH = mips_pkg::WIDTH,
    parameter int AW    = mips_pkg::AW
) (
    input  logic             rst_n_i,
    input  logic [AW-1:0]    ra_i,
    input  logic             we_i,
    input  logic [AW-1:0]    wa_i,
    input  logic [WIDTH-1:0] wd_i,
    input  logic [WIDTH-1:0] mem_data_i,
    output logic [WIDTH-1:0] rd_o
);
    import mips_pkg::*;

    always_comb begin
        rd_o = mem_data_i;
        if (!rst_n_i) begin
            rd_o = '0;
        end else if (ra_i == AW'(REG_ZERO)) begin
            rd_o = '0;
        end else if (we_i && (wa_i == ra_i)) begin
            rd_o = wd_i;
        end
    end

endmodule

// File: rtl/regfile_32x32.sv
// Two-read/one-write register file with $zero hard-wired, write-first
// bypass on both read ports and a saturating committed-write counter.
module regfile_32x32 #(
    parameter int WIDTH = mips_pkg::WIDTH,
    parameter int AW    = mips_pkg::AW,
    parameter int CNTW  = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             WE,
    input  logic [AW-1:0]    WA,
    input  logic [WIDTH-1:0] WD,
    input  logic [AW-1:0]    RA1,
    input  logic [AW-1:0]    RA2,
    output logic [WIDTH-1:0] RD1,
    output logic [WIDTH-1:0] RD2,
    output logic [CNTW-1:0]  WCNT
);
    import mips_pkg::*;

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CNTW-1:0]  wcnt_q;
    logic [CNTW-1:0]  wcnt_d;
    logic             wr_en;
    logic [WIDTH-1:0] mem_rd1;
    logic [WIDTH-1:0] mem_rd2;

    // Writes to $zero are discarded entirely, so they never reach the counter.
    assign wr_en   = WE && (WA != AW'(REG_ZERO));
    assign mem_rd1 = mem_q[RA1];
    assign mem_rd2 = mem_q[RA2];
    assign WCNT    = wcnt_q;

    always_comb begin
        wcnt_d = wcnt_q;
        if (wr_en && (wcnt_q != {CNTW{1'b1}})) begin
            wcnt_d = wcnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wcnt_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[WA] <= WD;
            end
            wcnt_q <= wcnt_d;
        end
    end

    regfile_rdport #(
        .WIDTH(WIDTH),
        .AW   (AW)
    ) u_rdport1 (
        .rst_n_i   (RST_N),
        .ra_i      (RA1),
        .we_i      (WE),
        .wa_i      (WA),
        .wd_i      (WD),
        .mem_data_i(mem_rd1),
        .rd_o      (RD1)
    );

    regfile_rdport #(
        .WIDTH(WIDTH),
        .AW   (AW)
    ) u_rdport2 (
        .rst_n_i   (RST_N),
        .ra_i      (RA2),
        .we_i      (WE),
        .wa_i      (WA),
        .wd_i      (WD),
        .mem_data_i(mem_rd2),
        .rd_o      (RD2)
    );

endmodule

// File: doc/regfile_32x32.md
# regfile_32x32

Two-read/one-write architectural register file for the single-cycle/pipelined MIPS datapath. Directly downstream of the 5-bit destination-select `mux41` (`WIDTH=5`): the mux's `Y` (rt / rd / $ra / spare) drives this block's write address `WA`. Read data feeds the ALU operand muxes. Storage is clocked; reads are combinational with same-cycle write bypass.

## Interface
- `WIDTH`, 32, data word width in bits.
- `AW`, 5, address width; must equal the `mux41` width parameter. Depth = 2^`AW`.
- `CNTW`, 16, width of the committed-write counter.

- `CLK`  in  1  rising-edge clock; the only clock.
- `RST_N`  in  1  synchronous, active-low reset; sampled on `CLK` rising edge.
- `WE`  in  1  write enable.
- `WA`  in  `AW`  write address (from `mux41.Y`).
- `WD`  in  `WIDTH`  write data.
- `RA1`  in  `AW`  read address, port 1 (rs).
- `RA2`  in  `AW`  read address, port 2 (rt).
- `RD1`  out  `WIDTH`  read data, port 1.
- `RD2`  out  `WIDTH`  read data, port 2.
- `WCNT`  out  `CNTW`  count of committed writes, saturating.

## Operation
- Array of 2^`AW` words. Register 0 ($zero) is not stored: reads always return 0, writes to it are dropped and not counted.
- Write: on rising `CLK` with `RST_N`=1, `WE`=1, `WA`≠0 -> `mem[WA]` <= `WD`; `WCNT` increments by 1.
- `WCNT` saturates at 2^`CNTW`−1; further writes leave it unchanged.
- Read port n (combinational), priority order:
  - `RST_N`=0 -> `RDn` = 0.
  - `RAn`=0 -> 0.
  - `WE`=1 and `WA`=`RAn` -> `WD` (write-first bypass; same-cycle read sees new value).
  - else `mem[RAn]`.
- Both ports independent; `RA1`=`RA2` is legal, both return identical data, including under bypass.
- X/Z on `WA` while `WE`=1 is illegal; bench flags it.
- No internal state machine beyond storage and counter; no back-pressure.

## Timing
- Reset: on rising `CLK` with `RST_N`=0, every `mem` word <= 0 and `WCNT` <= 0. Reset overrides a simultaneous write (write dropped, not counted).
- Reset outputs: `RD1`=`RD2`=0 combinationally while `RST_N`=0; `WCNT`=0 after first reset edge. Before the first reset edge, contents are undefined.
- Reset asserted mid-stream: state cleared at that edge; the cycle following deassertion behaves as a fresh file (all reads 0 until written).
- Write latency: 0 cycles visible via bypass on the write cycle; 1 cycle (after edge) visible via storage.
- Read latency: combinational from `RAn`, `WA`, `WE`, `WD`, `RST_N`; no registered outputs.
- `WCNT` is registered; updates on the same edge as the storage write.

## Structure
- Shared package `mips_pkg`: `AW`=5, `WIDTH`=32, register constants `REG_ZERO`=5'd0, `REG_RA`=5'd31, and mux select encodings used by `mux41` (rt=0, rd=1, ra=2, spare=3) so the datapath and this block agree.
- One sub-module: `regfile_rdport` (read-port mux + zero-check + bypass), instantiated twice. Storage, reset and `WCNT` stay in the top.

## Test plan
- Reset: hold `RST_N`=0 one edge with `WE`=1, `WA`=5, `WD`=32'hDEADBEEF -> after edge, `RD1` (`RA1`=5) = 0, `WCNT`=0; during reset `RD1`=`RD2`=0 for all addresses.
- Basic write/read: write 32'h12345678 to reg 8, then 32'hCAFEF00D to reg 31 -> next cycle `RA1`=8 gives 32'h12345678, `RA2`=31 gives 32'hCAFEF00D, `WCNT`=2.
- $zero: `WE`=1, `WA`=0, `WD`=32'hFFFFFFFF -> `RD1` (`RA1`=0) = 0 same cycle and after edge; `WCNT` unchanged.
- Bypass: reg 9 holds 32'h1; same cycle `WE`=1, `WA`=9, `WD`=32'h2, `RA1`=`RA2`=9 -> both read 32'h2 before the edge; 32'h2 from storage after it.
- Mux-driven write: drive `mux41` with D0=5'd4, D1=5'd10, D2=5'd31, S=2'b10 into `WA`, `WD`=32'hA5A5A5A5 -> reg 31 = 32'hA5A5A5A5, regs 4 and 10 unchanged.
- Mid-operation reset + saturation: with `CNTW`=2, four writes -> `WCNT`=3 (saturated); then pulse `RST_N`=0 one edge -> all reads 0, `WCNT`=0; next write to reg 3 -> `WCNT`=1.
